// File: rtl/fl_ckpt_ctrl_pkg.sv
// Shared types and sizes for the free-list branch-checkpoint controller.
package fl_ckpt_ctrl_pkg;
  localparam int FL_DEPTH = 32;
  localparam int CKPT_NUM = 4;
  localparam int TW       = $clog2(CKPT_NUM);
  localparam int HW       = $clog2(FL_DEPTH) + 1;

  typedef logic [TW-1:0] ckpt_tag_t;
  typedef logic [TW:0]   ckpt_ptr_t;
  typedef logic [HW-1:0] fl_head_t;

  typedef enum logic {RUN, FLUSH} ckpt_state_e;
endpackage

// File: rtl/fl_ckpt_ctrl_if.sv
// Rename / branch-resolve / free-list handshake bundle for the checkpoint controller.
interface fl_ckpt_ctrl_if;
  import fl_ckpt_ctrl_pkg::*;

  logic      br_alloc;
  fl_head_t  fl_head;
  logic      fl_deq;
  logic      ckpt_ready;
  ckpt_tag_t alloc_tag;
  logic      res_valid;
  ckpt_tag_t res_tag;
  logic      res_mispred;
  logic      fl_flush;
  fl_head_t  fl_recover_head;
  logic      rename_stall;

  modport master (
    output br_alloc, fl_head, fl_deq, res_valid, res_tag, res_mispred,
    input  ckpt_ready, alloc_tag, fl_flush, fl_recover_head, rename_stall
  );
  modport slave (
    input  br_alloc, fl_head, fl_deq, res_valid, res_tag, res_mispred,
    output ckpt_ready, alloc_tag, fl_flush, fl_recover_head, rename_stall
  );
endinterface

// File: rtl/fl_ckpt_age_mask.sv
// Marks every live slot strictly younger than tag, given the circular-buffer pointers.
module fl_ckpt_age_mask
  import fl_ckpt_ctrl_pkg::*;
(
  input  ckpt_ptr_t           old_ptr,
  input  ckpt_ptr_t           new_ptr,
  input  ckpt_tag_t           tag,
  output logic [CKPT_NUM-1:0] younger
);
  ckpt_ptr_t count;
  ckpt_tag_t off_t;
  ckpt_tag_t off_i;

  // Ages are distances from the oldest slot; live slots have distance < occupancy.
  always_comb begin
    count   = new_ptr - old_ptr;
    off_t   = tag - old_ptr[TW-1:0];
    off_i   = '0;
    younger = '0;
    for (int i = 0; i < CKPT_NUM; i++) begin
      off_i      = ckpt_tag_t'(i) - old_ptr[TW-1:0];
      younger[i] = (off_i > off_t) && ({1'b0, off_i} < count);
    end
  end
endmodule

// File: rtl/fl_ckpt_ctrl.sv
// Branch-checkpoint controller: snapshots free-list head per branch, retires in order, flushes on mispredict.
// Optional FL_CKPT_STATS_EN adds saturating alloc / mispredict / full-stall counters.
module fl_ckpt_ctrl
  import fl_ckpt_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fl_ckpt_ctrl_if.slave bus
`ifdef FL_CKPT_STATS_EN
  ,
  output logic [31:0]   stat_alloc,
  output logic [31:0]   stat_mispred,
  output logic [31:0]   stat_full_stall
`endif
);
  ckpt_state_e         state;
  ckpt_ptr_t           old_ptr, new_ptr, trunc_ptr;
  fl_head_t            ckpt_head [CKPT_NUM];
  logic [CKPT_NUM-1:0] valid, done, younger;
  logic [CKPT_NUM-1:0] alloc_oh, res_oh, ret_oh, kill;
  fl_head_t            rec_q;
  logic                empty, full, mispred, resolve_ok, do_alloc, do_retire, t_wrap;

  fl_ckpt_age_mask u_age (
    .old_ptr (old_ptr),
    .new_ptr (new_ptr),
    .tag     (bus.res_tag),
    .younger (younger)
  );

  assign empty      = (old_ptr == new_ptr);
  assign full       = (old_ptr[TW-1:0] == new_ptr[TW-1:0]) && (old_ptr[TW] != new_ptr[TW]);
  assign mispred    = bus.res_valid && bus.res_mispred && valid[bus.res_tag];
  assign resolve_ok = bus.res_valid && !bus.res_mispred && valid[bus.res_tag];
  assign do_alloc   = bus.br_alloc && bus.ckpt_ready && !mispred;
  assign do_retire  = !empty && valid[old_ptr[TW-1:0]] && done[old_ptr[TW-1:0]];

  // A tag below the oldest slot's index lives in the next lap of the buffer.
  assign t_wrap    = (bus.res_tag >= old_ptr[TW-1:0]) ? old_ptr[TW] : ~old_ptr[TW];
  assign trunc_ptr = {t_wrap, bus.res_tag} + 1'b1;

  assign bus.ckpt_ready      = !full && (state == RUN);
  assign bus.alloc_tag       = new_ptr[TW-1:0];
  assign bus.fl_flush        = (state == FLUSH);
  assign bus.rename_stall    = (state == FLUSH);
  assign bus.fl_recover_head = (state == FLUSH) ? rec_q : '0;

  always_comb begin
    alloc_oh = '0;
    alloc_oh[new_ptr[TW-1:0]] = do_alloc;
    res_oh = '0;
    res_oh[bus.res_tag] = resolve_ok | mispred;
    ret_oh = '0;
    ret_oh[old_ptr[TW-1:0]] = do_retire;
    kill = mispred ? younger : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      old_ptr <= '0;
      new_ptr <= '0;
      valid   <= '0;
      done    <= '0;
      rec_q   <= '0;
    end else begin
      state <= mispred ? FLUSH : RUN;
      if (mispred) rec_q <= ckpt_head[bus.res_tag];
      if (do_retire) old_ptr <= old_ptr + 1'b1;
      if (mispred)       new_ptr <= trunc_ptr;
      else if (do_alloc) new_ptr <= new_ptr + 1'b1;
      valid <= (valid & ~ret_oh & ~kill) | alloc_oh;
      done  <= (done | res_oh) & ~alloc_oh;
    end
  end

  // Snapshot storage is pure datapath; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_alloc) ckpt_head[new_ptr[TW-1:0]] <= bus.fl_head + fl_head_t'(bus.fl_deq);
  end

`ifdef FL_CKPT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_alloc      <= '0;
      stat_mispred    <= '0;
      stat_full_stall <= '0;
    end else begin
      if (do_alloc && stat_alloc != 32'hFFFF_FFFF) stat_alloc <= stat_alloc + 1'b1;
      if (mispred && stat_mispred != 32'hFFFF_FFFF) stat_mispred <= stat_mispred + 1'b1;
      if (bus.br_alloc && !bus.ckpt_ready && stat_full_stall != 32'hFFFF_FFFF)
        stat_full_stall <= stat_full_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// Directed bench for fl_ckpt_ctrl: alloc/full, in-order retire, mispredict flush, nested flush, wrap, reset mid-flush.
module tb_fl_ckpt_ctrl;
  import fl_ckpt_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fl_ckpt_ctrl_if bus();

`ifdef FL_CKPT_STATS_EN
  logic [31:0] stat_alloc, stat_mispred, stat_full_stall;
  fl_ckpt_ctrl dut (.clk(clk), .rst(rst), .bus(bus),
                    .stat_alloc(stat_alloc), .stat_mispred(stat_mispred),
                    .stat_full_stall(stat_full_stall));
`else
  fl_ckpt_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [5:0] h, input logic d,
                       input logic rv, input logic [1:0] rt, input logic rm);
    bus.br_alloc    = a;
    bus.fl_head     = h;
    bus.fl_deq      = d;
    bus.res_valid   = rv;
    bus.res_tag     = rt;
    bus.res_mispred = rm;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic alloc4;
    logic [5:0] heads [4];
    heads = '{6'd5, 6'd9, 6'd12, 6'd40};
    for (int k = 0; k < 4; k++) begin
      drive(1, heads[k], 1, 0, 0, 0);
      checks++; if (bus.alloc_tag !== 2'(k)) begin errors++; $display("FAIL alloc_tag[%0d]: got %0d want %0d", k, bus.alloc_tag, k); end
      tick;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.ckpt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.ckpt_ready); end
      checks++; if (bus.alloc_tag !== 2'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", bus.alloc_tag); end
      checks++; if (bus.fl_flush !== 1'b0 || bus.rename_stall !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b/%0b want 0/0", bus.fl_flush, bus.rename_stall); end
      checks++; if (bus.fl_recover_head !== 6'd0) begin errors++; $display("FAIL reset_head: got %0d want 0", bus.fl_recover_head); end
      tick;
    end
  endtask

  task automatic test_alloc_full;
    alloc4;
    checks++; if (bus.ckpt_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", bus.ckpt_ready); end
    drive(1, 6'd20, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.ckpt_ready !== 1'b0 || bus.alloc_tag !== 2'd0) begin errors++; $display("FAIL full_ignore: got ready=%0b tag=%0d want 0/0", bus.ckpt_ready, bus.alloc_tag); end
  endtask

  task automatic test_retire_order;
    drive(0, 0, 0, 1, 2'd2, 0); tick;
    drive(0, 0, 0, 1, 2'd1, 0); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.ckpt_ready !== 1'b0) begin errors++; $display("FAIL retire_blocked: got %0b want 0", bus.ckpt_ready); end
    drive(0, 0, 0, 1, 2'd0, 0); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.ckpt_ready !== 1'b0) begin errors++; $display("FAIL retire_latency: got %0b want 0", bus.ckpt_ready); end
    tick;
    checks++; if (bus.ckpt_ready !== 1'b1) begin errors++; $display("FAIL retire_first: got %0b want 1", bus.ckpt_ready); end
    tick; tick;
    // slots 0..2 gone, slot 3 still live: exactly three more allocations fit
    drive(1, 6'd63, 1, 0, 0, 0); tick;
    drive(1, 6'd1, 0, 0, 0, 0); tick;
    checks++; if (bus.ckpt_ready !== 1'b1 || bus.alloc_tag !== 2'd2) begin errors++; $display("FAIL retire_room: got ready=%0b tag=%0d want 1/2", bus.ckpt_ready, bus.alloc_tag); end
    drive(1, 6'd2, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.ckpt_ready !== 1'b0) begin errors++; $display("FAIL retire_stop: got %0b want 0", bus.ckpt_ready); end
  endtask

  task automatic test_mispredict;
    do_reset;
    alloc4;
    drive(0, 0, 0, 1, 2'd1, 1);
    checks++; if (bus.fl_flush !== 1'b0) begin errors++; $display("FAIL mp_early: got %0b want 0", bus.fl_flush); end
    tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.fl_flush !== 1'b1 || bus.rename_stall !== 1'b1 || bus.ckpt_ready !== 1'b0) begin errors++; $display("FAIL mp_flush: got flush=%0b stall=%0b ready=%0b want 1/1/0", bus.fl_flush, bus.rename_stall, bus.ckpt_ready); end
    checks++; if (bus.fl_recover_head !== 6'd10) begin errors++; $display("FAIL mp_head: got %0d want 10", bus.fl_recover_head); end
    tick;
    checks++; if (bus.fl_flush !== 1'b0 || bus.rename_stall !== 1'b0 || bus.fl_recover_head !== 6'd0) begin errors++; $display("FAIL mp_end: got flush=%0b stall=%0b head=%0d want 0/0/0", bus.fl_flush, bus.rename_stall, bus.fl_recover_head); end
    checks++; if (bus.alloc_tag !== 2'd2 || bus.ckpt_ready !== 1'b1) begin errors++; $display("FAIL mp_tag: got tag=%0d ready=%0b want 2/1", bus.alloc_tag, bus.ckpt_ready); end
    drive(0, 0, 0, 1, 2'd3, 1); tick;
    checks++; if (bus.fl_flush !== 1'b0) begin errors++; $display("FAIL mp_inv3: got %0b want 0", bus.fl_flush); end
    drive(0, 0, 0, 1, 2'd2, 1); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.fl_flush !== 1'b0) begin errors++; $display("FAIL mp_inv2: got %0b want 0", bus.fl_flush); end
  endtask

  task automatic test_nested_flush;
    drive(1, 6'd20, 0, 0, 0, 0); tick;
    drive(1, 6'd30, 0, 1, 2'd2, 1); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.fl_flush !== 1'b1 || bus.fl_recover_head !== 6'd20) begin errors++; $display("FAIL nest_first: got flush=%0b head=%0d want 1/20", bus.fl_flush, bus.fl_recover_head); end
    checks++; if (bus.alloc_tag !== 2'd3) begin errors++; $display("FAIL nest_drop: got %0d want 3", bus.alloc_tag); end
    drive(0, 0, 0, 1, 2'd0, 1); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.fl_flush !== 1'b1 || bus.fl_recover_head !== 6'd6) begin errors++; $display("FAIL nest_second: got flush=%0b head=%0d want 1/6", bus.fl_flush, bus.fl_recover_head); end
    tick;
    checks++; if (bus.fl_flush !== 1'b0 || bus.ckpt_ready !== 1'b1 || bus.alloc_tag !== 2'd1) begin errors++; $display("FAIL nest_end: got flush=%0b ready=%0b tag=%0d want 0/1/1", bus.fl_flush, bus.ckpt_ready, bus.alloc_tag); end
  endtask

  task automatic test_wrap;
    do_reset;
    for (int k = 0; k < 10; k++) begin
      drive(1, 6'(k * 7), 0, k > 0, 2'(k - 1), 0);
      checks++; if (bus.alloc_tag !== 2'(k) || bus.ckpt_ready !== 1'b1) begin errors++; $display("FAIL wrap_tag[%0d]: got tag=%0d ready=%0b want %0d/1", k, bus.alloc_tag, bus.ckpt_ready, k % 4); end
      tick;
    end
    drive(0, 0, 0, 0, 0, 0); tick;
    drive(1, 6'd50, 1, 0, 0, 0); tick;
    drive(1, 6'd51, 1, 0, 0, 0); tick;
    drive(1, 6'd52, 1, 0, 0, 0); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.ckpt_ready !== 1'b0) begin errors++; $display("FAIL wrap_full: got %0b want 0", bus.ckpt_ready); end
    // live order 1,2,3,0: tag 0 is the only slot younger than tag 3
    drive(0, 0, 0, 1, 2'd3, 1); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.fl_flush !== 1'b1 || bus.fl_recover_head !== 6'd52) begin errors++; $display("FAIL wrap_mp: got flush=%0b head=%0d want 1/52", bus.fl_flush, bus.fl_recover_head); end
    tick;
    checks++; if (bus.alloc_tag !== 2'd0 || bus.ckpt_ready !== 1'b1) begin errors++; $display("FAIL wrap_trunc: got tag=%0d ready=%0b want 0/1", bus.alloc_tag, bus.ckpt_ready); end
    drive(0, 0, 0, 1, 2'd0, 1); tick;
    checks++; if (bus.fl_flush !== 1'b0) begin errors++; $display("FAIL wrap_killed: got %0b want 0", bus.fl_flush); end
    drive(0, 0, 0, 1, 2'd2, 1); tick;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.fl_flush !== 1'b1 || bus.fl_recover_head !== 6'd51) begin errors++; $display("FAIL wrap_kept: got flush=%0b head=%0d want 1/51", bus.fl_flush, bus.fl_recover_head); end
    rst = 1'b1; tick;
    checks++; if (bus.fl_flush !== 1'b0 || bus.rename_stall !== 1'b0 || bus.fl_recover_head !== 6'd0) begin errors++; $display("FAIL rst_flush: got flush=%0b stall=%0b head=%0d want 0/0/0", bus.fl_flush, bus.rename_stall, bus.fl_recover_head); end
    checks++; if (bus.ckpt_ready !== 1'b1 || bus.alloc_tag !== 2'd0) begin errors++; $display("FAIL rst_state: got ready=%0b tag=%0d want 1/0", bus.ckpt_ready, bus.alloc_tag); end
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    test_reset;
    test_alloc_full;
    test_retire_order;
    test_mispredict;
    test_nested_flush;
    test_wrap;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
